// File: rtl/op_lut_arb_defs.sv
// Shared definitions for the op_lut table arbiter.
// FSM encodings, requester IDs and stats counter width.
package op_lut_arb_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_ISSUE   = 3'b010,
        ST_CAPTURE = 3'b100
    } state_t;

    localparam logic REQ_DP  = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    localparam int STAT_W = 32;

endpackage

// File: rtl/op_lut_table_arbiter_if.sv
// Requester and table RAM bus of the op_lut table arbiter.
// slave = arbiter side, master = datapath/CPU/RAM side.
interface op_lut_table_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 104
);
    logic                  dp_req;
    logic [ADDR_WIDTH-1:0] dp_addr;
    logic                  dp_gnt;
    logic [DATA_WIDTH-1:0] dp_rdata;
    logic                  dp_rdata_vld;

    logic                  cpu_req;
    logic                  cpu_rnw;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  tbl_en;
    logic                  tbl_we;
    logic [ADDR_WIDTH-1:0] tbl_addr;
    logic [DATA_WIDTH-1:0] tbl_wdata;
    logic [DATA_WIDTH-1:0] tbl_rdata;

    modport slave (
        input  dp_req, dp_addr,
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        input  tbl_rdata,
        output dp_gnt, dp_rdata, dp_rdata_vld,
        output cpu_ack, cpu_rdata,
        output tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

    modport master (
        output dp_req, dp_addr,
        output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
        output tbl_rdata,
        input  dp_gnt, dp_rdata, dp_rdata_vld,
        input  cpu_ack, cpu_rdata,
        input  tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

endinterface

// File: rtl/op_lut_arb_stats.sv
// Grant and CPU wait statistics for the op_lut table arbiter.
// Only instantiated when OP_LUT_ARB_STATS_EN is defined.
module op_lut_arb_stats
    import op_lut_arb_defs::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_dp_gnt,
    input  logic              i_cpu_gnt,
    input  logic              i_cpu_wait,
    output logic [STAT_W-1:0] o_dp_grants,
    output logic [STAT_W-1:0] o_cpu_grants,
    output logic [STAT_W-1:0] o_cpu_wait_cycles
);

    logic [STAT_W-1:0] r_dp_grants;
    logic [STAT_W-1:0] r_cpu_grants;
    logic [STAT_W-1:0] r_cpu_wait;

    // Free-running wrapping counters bumped by one-cycle strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dp_grants  <= '0;
            r_cpu_grants <= '0;
            r_cpu_wait   <= '0;
        end else begin
            if (i_dp_gnt)   r_dp_grants  <= r_dp_grants + STAT_W'(1);
            if (i_cpu_gnt)  r_cpu_grants <= r_cpu_grants + STAT_W'(1);
            if (i_cpu_wait) r_cpu_wait   <= r_cpu_wait + STAT_W'(1);
        end
    end

    assign o_dp_grants       = r_dp_grants;
    assign o_cpu_grants      = r_cpu_grants;
    assign o_cpu_wait_cycles = r_cpu_wait;

endmodule

// File: rtl/op_lut_table_arbiter.sv
// Single-port LUT RAM arbiter: datapath priority, bounded CPU starvation.
// Optional stats outputs enabled by OP_LUT_ARB_STATS_EN.
module op_lut_table_arbiter
    import op_lut_arb_defs::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 104,
    parameter int MAX_DP_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    op_lut_table_arbiter_if.slave bus
`ifdef OP_LUT_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_dp_grants,
    output logic [STAT_W-1:0]     stat_cpu_grants,
    output logic [STAT_W-1:0]     stat_cpu_wait_cycles
`endif
);

    localparam int SW = $clog2(MAX_DP_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DP_STREAK);

    state_t                r_state;
    logic                  r_owner;
    logic                  r_rnw;
    logic [SW-1:0]         r_streak;
    logic                  r_dp_gnt;
    logic                  r_dp_vld;
    logic                  r_cpu_ack;
    logic [DATA_WIDTH-1:0] r_dp_rdata;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic                  r_tbl_en;
    logic                  r_tbl_we;
    logic [ADDR_WIDTH-1:0] r_tbl_addr;
    logic [DATA_WIDTH-1:0] r_tbl_wdata;

    logic w_idle;
    logic w_cpu_win;
    logic w_dp_win;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_cpu_win = w_idle && bus.cpu_req &&
                       (!bus.dp_req || (r_streak == STREAK_MAX));
    assign w_dp_win  = w_idle && bus.dp_req && !w_cpu_win;

    // Arbitrate in IDLE, drive the RAM in ISSUE, register data in CAPTURE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_owner     <= REQ_DP;
            r_rnw       <= 1'b1;
            r_dp_gnt    <= 1'b0;
            r_dp_vld    <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_dp_rdata  <= '0;
            r_cpu_rdata <= '0;
            r_tbl_en    <= 1'b0;
            r_tbl_we    <= 1'b0;
            r_tbl_addr  <= '0;
            r_tbl_wdata <= '0;
        end else begin
            r_dp_gnt  <= 1'b0;
            r_dp_vld  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_tbl_en  <= 1'b0;
            r_tbl_we  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cpu_win) begin
                        r_owner     <= REQ_CPU;
                        r_rnw       <= bus.cpu_rnw;
                        r_tbl_addr  <= bus.cpu_addr;
                        r_tbl_wdata <= bus.cpu_wdata;
                        r_tbl_en    <= 1'b1;
                        r_tbl_we    <= !bus.cpu_rnw;
                        r_state     <= ST_ISSUE;
                    end else if (w_dp_win) begin
                        r_owner    <= REQ_DP;
                        r_rnw      <= 1'b1;
                        r_tbl_addr <= bus.dp_addr;
                        r_tbl_en   <= 1'b1;
                        r_dp_gnt   <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (r_owner == REQ_DP) begin
                        r_dp_rdata <= bus.tbl_rdata;
                        r_dp_vld   <= 1'b1;
                    end else begin
                        if (r_rnw) r_cpu_rdata <= bus.tbl_rdata;
                        r_cpu_ack <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Consecutive dp grants while the CPU waits; saturates at the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_streak <= '0;
        end else if (!bus.cpu_req || w_cpu_win) begin
            r_streak <= '0;
        end else if (w_dp_win && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + SW'(1);
        end
    end

    assign bus.dp_gnt       = r_dp_gnt;
    assign bus.dp_rdata     = r_dp_rdata;
    assign bus.dp_rdata_vld = r_dp_vld;
    assign bus.cpu_ack      = r_cpu_ack;
    assign bus.cpu_rdata    = r_cpu_rdata;
    assign bus.tbl_en       = r_tbl_en;
    assign bus.tbl_we       = r_tbl_we;
    assign bus.tbl_addr     = r_tbl_addr;
    assign bus.tbl_wdata    = r_tbl_wdata;

`ifdef OP_LUT_ARB_STATS_EN
    logic w_cpu_busy;
    logic w_cpu_wait;

    assign w_cpu_busy = (r_owner == REQ_CPU) && !w_idle;
    assign w_cpu_wait = bus.cpu_req && !w_cpu_busy;

    op_lut_arb_stats u_stats (
        .clk               (clk),
        .resetn            (resetn),
        .i_dp_gnt          (w_dp_win),
        .i_cpu_gnt         (w_cpu_win),
        .i_cpu_wait        (w_cpu_wait),
        .o_dp_grants       (stat_dp_grants),
        .o_cpu_grants      (stat_cpu_grants),
        .o_cpu_wait_cycles (stat_cpu_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_op_lut_table_arbiter.sv
// Self-checking bench for op_lut_table_arbiter with a scoreboard.
// Stats checks are compiled in when OP_LUT_ARB_STATS_EN is defined.
module tb_op_lut_table_arbiter;

    localparam int AW = 5;
    localparam int DW = 104;

    logic clk;
    logic resetn;

    op_lut_table_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef OP_LUT_ARB_STATS_EN
    logic [31:0] stat_dp_grants;
    logic [31:0] stat_cpu_grants;
    logic [31:0] stat_cpu_wait_cycles;
`endif

    op_lut_table_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MAX_DP_STREAK (4)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .bus                  (bus.slave)
`ifdef OP_LUT_ARB_STATS_EN
        ,
        .stat_dp_grants       (stat_dp_grants),
        .stat_cpu_grants      (stat_cpu_grants),
        .stat_cpu_wait_cycles (stat_cpu_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return DW'(104'hABCD);
        return {8'(i), 64'h0, 32'hC0DE_0000 + 32'(i)};
    endfunction

    // Table RAM model: one-cycle read latency, read-before-write.
    logic [DW-1:0] mem [32];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.tbl_en) begin
            if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
            bus.tbl_rdata <= mem[bus.tbl_addr];
        end
    end

    // Reference contents and scoreboard state.
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] dpq [$];
    logic [DW-1:0] cpuq [$];
    logic [DW-1:0] cpu_last;
    bit            grant_log [$];
    bit            auto_push;

    // Monitor: log grants, pop and compare responses.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.tbl_en) begin
                grant_log.push_back(!bus.dp_gnt);
                if (auto_push) begin
                    if (bus.dp_gnt) begin
                        dpq.push_back(ref_mem[bus.dp_addr]);
                    end else begin
                        cpu_last = ref_mem[bus.cpu_addr];
                        cpuq.push_back(cpu_last);
                    end
                end
            end
            if (bus.dp_rdata_vld) begin
                if (dpq.size() == 0) chk("dp_spurious", bus.dp_rdata_vld, 0);
                else chk("dp_rdata", bus.dp_rdata, dpq.pop_front());
            end
            if (bus.cpu_ack) begin
                if (cpuq.size() == 0) chk("cpu_spurious", bus.cpu_ack, 0);
                else chk("cpu_rdata", bus.cpu_rdata, cpuq.pop_front());
            end
        end
    end

    task automatic wait_dp_gnt();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.dp_gnt) break;
        end
        chk("dp_gnt_seen", bus.dp_gnt, 1);
        bus.dp_req = 1'b0;
    endtask

    task automatic wait_cpu_ack();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) break;
        end
        chk("cpu_ack_seen", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (dpq.size() == 0 && cpuq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 128'(dpq.size() + cpuq.size()), 0);
    endtask

    task automatic dp_read(input int a);
        bus.dp_addr = AW'(a);
        bus.dp_req  = 1'b1;
        dpq.push_back(ref_mem[a]);
        wait_dp_gnt();
        drain();
    endtask

    task automatic cpu_access(input bit rnw, input int a,
                              input logic [DW-1:0] wd);
        bus.cpu_rnw   = rnw;
        bus.cpu_addr  = AW'(a);
        bus.cpu_wdata = wd;
        if (rnw) cpu_last = ref_mem[a];
        else ref_mem[a] = wd;
        cpuq.push_back(cpu_last);
        bus.cpu_req = 1'b1;
        wait_cpu_ack();
        drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   bus.dp_gnt, 0);
        chk({tag, "_vld"},   bus.dp_rdata_vld, 0);
        chk({tag, "_ack"},   bus.cpu_ack, 0);
        chk({tag, "_en"},    bus.tbl_en, 0);
        chk({tag, "_we"},    bus.tbl_we, 0);
        chk({tag, "_addr"},  bus.tbl_addr, 0);
        chk({tag, "_wdata"}, bus.tbl_wdata, 0);
        chk({tag, "_dprd"},  bus.dp_rdata, 0);
        chk({tag, "_cpurd"}, bus.cpu_rdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
        cpu_last      = '0;
        auto_push     = 1'b0;
        resetn        = 1'b0;
        bus.dp_req    = 1'b0;
        bus.dp_addr   = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_rnw   = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;

        // Single dp read with exact cycle timing.
        @(posedge clk); #1;
        bus.dp_addr = 5'd5;
        bus.dp_req  = 1'b1;
        dpq.push_back(ref_mem[5]);
        @(negedge clk);
        chk("t1_c0_en", bus.tbl_en, 0);
        @(negedge clk);
        chk("t1_c1_gnt", bus.dp_gnt, 1);
        chk("t1_c1_en", bus.tbl_en, 1);
        chk("t1_c1_addr", bus.tbl_addr, 5);
        chk("t1_c1_we", bus.tbl_we, 0);
        bus.dp_req = 1'b0;
        @(negedge clk);
        chk("t1_c2_vld", bus.dp_rdata_vld, 0);
        @(negedge clk);
        chk("t1_c3_vld", bus.dp_rdata_vld, 1);
        chk("t1_c3_data", bus.dp_rdata, 104'hABCD);
        drain();

        // CPU write with exact timing, then read back.
        @(posedge clk); #1;
        bus.cpu_rnw   = 1'b0;
        bus.cpu_addr  = 5'd7;
        bus.cpu_wdata = DW'(104'h1234);
        ref_mem[7]    = DW'(104'h1234);
        cpuq.push_back(cpu_last);
        bus.cpu_req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_c1_en", bus.tbl_en, 1);
        chk("wr_c1_we", bus.tbl_we, 1);
        chk("wr_c1_addr", bus.tbl_addr, 7);
        chk("wr_c1_wdata", bus.tbl_wdata, 104'h1234);
        @(negedge clk);
        chk("wr_c2_ack", bus.cpu_ack, 0);
        @(negedge clk);
        chk("wr_c3_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        drain();
        cpu_access(1'b1, 7, '0);
        chk("rd7_data", bus.cpu_rdata, 104'h1234);
        cpu_access(1'b1, 20, '0);
        dp_read(7);

        // Starvation bound: 4 dp grants then one cpu grant, repeating.
        grant_log.delete();
        auto_push = 1'b1;
        @(posedge clk); #1;
        bus.dp_addr  = 5'd3;
        bus.cpu_addr = 5'd9;
        bus.cpu_rnw  = 1'b1;
        bus.dp_req   = 1'b1;
        bus.cpu_req  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= 10) break;
        end
        bus.dp_req  = 1'b0;
        bus.cpu_req = 1'b0;
        auto_push   = 1'b0;
        chk("starve_cnt", 128'(grant_log.size() >= 10), 1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            chk($sformatf("starve_%0d", i), grant_log[i],
                128'(i == 4 || i == 9));
        drain();

        // Simultaneous requests with cleared streak: dp first, then cpu.
        grant_log.delete();
        @(posedge clk); #1;
        bus.dp_addr  = 5'd12;
        bus.cpu_addr = 5'd11;
        bus.cpu_rnw  = 1'b1;
        dpq.push_back(ref_mem[12]);
        cpu_last = ref_mem[11];
        cpuq.push_back(cpu_last);
        bus.dp_req  = 1'b1;
        bus.cpu_req = 1'b1;
        wait_dp_gnt();
        wait_cpu_ack();
        drain();
        chk("sim_cnt", 128'(grant_log.size()), 2);
        if (grant_log.size() >= 2) begin
            chk("sim_first_dp", grant_log[0], 0);
            chk("sim_then_cpu", grant_log[1], 1);
        end

        // Reset during ISSUE abandons the access.
        @(posedge clk); #1;
        bus.dp_addr = 5'd2;
        bus.dp_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue_en", bus.tbl_en, 1);
        resetn     = 1'b0;
        bus.dp_req = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        cpu_last = '0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_resp", 128'(bus.dp_rdata_vld | bus.cpu_ack), 0);
        end
        dp_read(5);
        cpu_access(1'b1, 7, '0);

`ifdef OP_LUT_ARB_STATS_EN
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        chk("stat_rst_dp", stat_dp_grants, 0);
        dp_read(1);
        @(posedge clk); #1;
        bus.dp_addr = 5'd2;
        bus.dp_req  = 1'b1;
        dpq.push_back(ref_mem[2]);
        @(posedge clk); #1;
        bus.cpu_addr = 5'd4;
        bus.cpu_rnw  = 1'b1;
        cpu_last = ref_mem[4];
        cpuq.push_back(cpu_last);
        bus.cpu_req = 1'b1;
        wait_dp_gnt();
        wait_cpu_ack();
        drain();
        dp_read(6);
        cpu_access(1'b0, 8, DW'(104'h55));
        repeat (2) @(negedge clk);
        chk("stat_dp", stat_dp_grants, 3);
        chk("stat_cpu", stat_cpu_grants, 2);
        chk("stat_wait", stat_cpu_wait_cycles, 4);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/op_lut_table_arbiter.md
Name: op_lut_table_arbiter

Overview:
- Arbitrates one single-port lookup table RAM (LPM/ARP/dest-IP-filter entries) between two requesters.
- Requester 1 is the router output-port-lookup datapath (read-only lookups). Requester 2 is the CPU register interface (reads and writes).
- Datapath has priority. A streak counter guarantees the CPU a slot after a bounded number of consecutive datapath grants.
- Sits between the lookup preprocess blocks, the register slave and the table RAM.

Parameters:
- ADDR_WIDTH, 5, table address width (32 entries).
- DATA_WIDTH, 104, table entry width (IP, mask, next-hop IP, port one-hot).
- MAX_DP_STREAK, 4, maximum consecutive datapath grants while cpu_req is pending. Must be >= 1; 1 means strict alternation.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- dp_req  in  1  datapath lookup request (level, held until dp_gnt)
- dp_addr  in  ADDR_WIDTH  datapath lookup index
- dp_gnt  out  1  one-cycle pulse: datapath access accepted
- dp_rdata  out  DATA_WIDTH  lookup result
- dp_rdata_vld  out  1  one-cycle pulse: dp_rdata valid
- cpu_req  in  1  CPU access request (level, held until cpu_ack)
- cpu_rnw  in  1  1=read, 0=write
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  one-cycle pulse: access complete
- cpu_rdata  out  DATA_WIDTH  CPU read data, valid with cpu_ack
- tbl_en  out  1  RAM enable
- tbl_we  out  1  RAM write enable
- tbl_addr  out  ADDR_WIDTH  RAM address
- tbl_wdata  out  DATA_WIDTH  RAM write data
- tbl_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after tbl_en

Behaviour:
- Clocking and reset: single clock clk; reset is asynchronous, active-low (resetn).
- Reset values: all outputs 0; state IDLE; streak counter 0.
- Reset mid-access abandons the in-flight access; no gnt, ack or vld is produced for it.
- State machine: one-hot states IDLE, ISSUE, CAPTURE.
- IDLE: evaluate requests in cycle N.
  - cpu wins if cpu_req && (!dp_req || streak==MAX_DP_STREAK).
  - else dp wins if dp_req.
  - else stay in IDLE.
  - The winner's address/data/rnw are latched; go to ISSUE.
- ISSUE (cycle N+1):
  - tbl_en=1; tbl_addr = latched address.
  - tbl_we=1 only for a CPU write; tbl_wdata = latched cpu_wdata.
  - The winner's gnt pulses (dp_gnt, or internal cpu grant).
  - Go to CAPTURE.
- CAPTURE (cycle N+2): tbl_rdata is registered into dp_rdata or cpu_rdata. Go to IDLE.
- Response at cycle N+3:
  - dp_rdata_vld or cpu_ack pulses for one cycle, concurrent with IDLE arbitrating the next request.
  - CPU writes also ack at N+3; cpu_rdata is unchanged on writes.
- Throughput: one access per 3 cycles. Next tbl_en is at N+4 at the earliest.
- Requesters may deassert req after gnt/ack. A req still high in IDLE after the response starts a new access.
  - CPU: cpu_req must drop in the ack cycle, or a second access results.
- Streak counter (saturating at MAX_DP_STREAK):
  - increments on a dp grant while cpu_req=1;
  - clears on a cpu grant, and in any cycle with cpu_req=0.
- Simultaneous dp_req and cpu_req with streak<MAX_DP_STREAK: dp wins.
- tbl_en/tbl_we are 0 outside ISSUE. tbl_addr/tbl_wdata hold their last values.
- dp_rdata and cpu_rdata hold their values until the next capture for the same requester.

Optional Feature:
- Macro OP_LUT_ARB_STATS_EN adds outputs stat_dp_grants[31:0], stat_cpu_grants[31:0] and stat_cpu_wait_cycles[31:0].
  - stat_cpu_wait_cycles counts cycles with cpu_req=1 and no cpu access in progress.
  - All three wrap at 2^32 and reset to 0.
- Without the macro these ports and counters do not exist; arbitration timing is identical either way.

Decomposition:
- Shared package/include op_lut_arb_defs:
  - state encodings IDLE/ISSUE/CAPTURE;
  - requester ID constants REQ_DP=0, REQ_CPU=1;
  - the stats counter width.
- Sub-module op_lut_arb_stats, instantiated only under OP_LUT_ARB_STATS_EN: three counters driven by grant and wait strobes.

Test Plan:
- Single dp read:
  - Stimulus: preload entry 5 = 0xABCD; dp_req=1, dp_addr=5 at cycle 0.
  - Response: tbl_en=1, tbl_addr=5 at cycle 1; dp_gnt at cycle 1; dp_rdata_vld=1 and dp_rdata=0xABCD at cycle 3.
- CPU write then read:
  - Stimulus: write 0x1234 to addr 7; then read addr 7.
  - Response: tbl_we=1 in the write ISSUE; cpu_ack at cycle 3; read returns cpu_rdata=0x1234 with cpu_ack.
- Starvation bound:
  - Stimulus: dp_req held high continuously; cpu_req raised at cycle 0; MAX_DP_STREAK=4.
  - Response: exactly 4 dp grants, then a cpu grant; the pattern repeats.
- Simultaneous requests:
  - Stimulus: cpu_req and dp_req both rise in the same cycle with streak=0.
  - Response: dp granted first; cpu granted on the next arbitration.
- Reset mid-access:
  - Stimulus: resetn=0 during ISSUE.
  - Response: all outputs 0 immediately; no dp_rdata_vld or cpu_ack afterwards; the next request after release completes normally.
- Stats (OP_LUT_ARB_STATS_EN):
  - Stimulus: 3 dp accesses and 2 cpu accesses, with cpu waiting 4 cycles.
  - Response: stat_dp_grants=3, stat_cpu_grants=2, stat_cpu_wait_cycles=4.
